contador_multidigito: RTL and testbench

//  Parametrised N-digit BCD up/down counter with time-multiplexed 7-segment display driver.

---
 rtl/contador_pkg.sv | 26 ++
 rtl/contador_multidigito_seg7_decoder.sv | 30 +++
 rtl/contador_multidigito.sv | 138 +++++++++++++
 tb/tb_contador_multidigito.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared types and constants for the multi-digit BCD counter: digit type,
// 7-segment patterns (active-high gfedcba) and the one-hot digit-select helper.
package contador_pkg;

  typedef logic [3:0] bcd_t;

  localparam int MAX_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/contador_multidigito_seg7_decoder.sv
// Combinational BCD to 7-segment (gfedcba, active-high) decoder with blanking.
// Non-decimal codes produce an unlit digit.
module seg7_decoder
  import contador_pkg::*;
(
  input  bcd_t       digit,
  input  logic       blank,
  output logic [6:0] segs
);

  always_comb begin
    segs = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    segs = SEG_0;
        4'd1:    segs = SEG_1;
        4'd2:    segs = SEG_2;
        4'd3:    segs = SEG_3;
        4'd4:    segs = SEG_4;
        4'd5:    segs = SEG_5;
        4'd6:    segs = SEG_6;
        4'd7:    segs = SEG_7;
        4'd8:    segs = SEG_8;
        4'd9:    segs = SEG_9;
        default: segs = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/contador_multidigito.sv
// N-digit BCD up/down counter with prescaler and time-multiplexed 7-segment driver.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module contador_multidigito
  import contador_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 1000000,
  parameter int SCAN_DIV       = 5000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clear,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  localparam logic [7:0]            SEG_POL = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_POL = (SEL_ACTIVE_LOW != 0) ? '1 : '0;

  logic [TW-1:0] presc_q;
  logic          tick;

  assign tick = en && (presc_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      presc_q <= '0;
    end else if (en) begin
      presc_q <= tick ? '0 : presc_q + TW'(1);
    end
  end

  // term[i]: digit i sits at the value that rolls over in the current direction.
  bcd_t [NUM_DIGITS-1:0] digit_q;
  logic [NUM_DIGITS-1:0] term;
  logic [NUM_DIGITS-1:0] carry_in;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_t q;

    assign digit_q[i] = q;
    assign term[i]    = up_dn ? (q == 4'd9) : (q == 4'd0);

    if (i == 0) begin : g_first
      assign carry_in[i] = tick;
    end else begin : g_rest
      assign carry_in[i] = tick && (&term[i-1:0]);
    end

    always_ff @(posedge clk) begin
      if (rst || clear) begin
        q <= 4'd0;
      end else if (carry_in[i]) begin
        if (up_dn) q <= term[i] ? 4'd0 : q + 4'd1;
        else       q <= term[i] ? 4'd9 : q - 4'd1;
      end
    end
  end

  assign count_bcd = digit_q;

  always_ff @(posedge clk) begin
    if (rst || clear) wrap <= 1'b0;
    else              wrap <= carry_in[NUM_DIGITS-1] && term[NUM_DIGITS-1];
  end

  logic [SW-1:0] scan_timer;
  logic [IW-1:0] scan_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_timer <= '0;
      scan_idx   <= '0;
    end else if (scan_timer == SCAN_LAST) begin
      scan_timer <= '0;
      scan_idx   <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
    end else begin
      scan_timer <= scan_timer + SW'(1);
    end
  end

  bcd_t       cur_digit;
  logic       cur_blank;
  logic [6:0] cur_segs;

  assign cur_digit = digit_q[scan_idx];

`ifdef LEADING_ZERO_BLANK_EN
  // blank_vec[k]: digit k and every digit above it are zero.
  logic [NUM_DIGITS-1:0] blank_vec;

  always_comb begin
    logic acc;
    acc       = 1'b1;
    blank_vec = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      acc          = acc && (digit_q[k] == 4'd0);
      blank_vec[k] = acc;
    end
    blank_vec[0] = 1'b0;
  end

  assign cur_blank = blank_vec[scan_idx];
`else
  assign cur_blank = 1'b0;
`endif

  seg7_decoder u_dec (
    .digit (cur_digit),
    .blank (cur_blank),
    .segs  (cur_segs)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_POL;
      sel <= SEL_POL;
    end else begin
      seg <= {1'b0, cur_segs} ^ SEG_POL;
      sel <= NUM_DIGITS'(onehot(3'(scan_idx))) ^ SEL_POL;
    end
  end

endmodule

// File: tb/tb_contador_multidigito.sv
// Bench for contador_multidigito (2 digits, TICK_DIV=4, SCAN_DIV=2) against an
// integer-arithmetic reference model; honours LEADING_ZERO_BLANK_EN if defined.
module tb_contador_multidigito;

  localparam int ND   = 2;
  localparam int TD   = 4;
  localparam int SD   = 2;
  localparam int MODV = 10 ** ND;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ_SEG = 8'h00;
`else
  localparam logic [7:0] LZ_SEG = 8'h3F;
`endif

  logic            clk = 1'b0;
  logic            rst, en, up_dn, clear;
  logic [7:0]      seg;
  logic [ND-1:0]   sel;
  logic [4*ND-1:0] count_bcd;
  logic            wrap;

  always #5 clk = ~clk;

  contador_multidigito #(
    .NUM_DIGITS     (ND),
    .TICK_DIV       (TD),
    .SCAN_DIV       (SD),
    .SEG_ACTIVE_LOW (0),
    .SEL_ACTIVE_LOW (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up_dn     (up_dn),
    .clear     (clear),
    .seg       (seg),
    .sel       (sel),
    .count_bcd (count_bcd),
    .wrap      (wrap)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: count is a plain integer modulo 10^ND.
  logic [6:0]    seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int            m_presc, m_count, m_scan_t, m_idx, post_rst;
  logic          m_wrap;
  logic [ND-1:0] m_sel;
  logic [7:0]    m_seg;

  function automatic int pow10(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [4*ND-1:0] bcd_of(input int c);
    logic [4*ND-1:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((c / pow10(i)) % 10);
    return r;
  endfunction

  function automatic logic [7:0] disp(input int c, input int idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (c / pow10(idx)) == 0) return 8'h00;
`endif
    return {1'b0, seg_tab[(c / pow10(idx)) % 10]};
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_presc = 0; m_count = 0; m_scan_t = 0; m_idx = 0;
      m_wrap = 1'b0; m_sel = '0; m_seg = 8'h00; post_rst = 0;
    end else begin
      m_sel = ND'(1 << m_idx);
      m_seg = disp(m_count, m_idx);
      if (m_scan_t == SD - 1) begin
        m_scan_t = 0;
        m_idx    = (m_idx + 1) % ND;
      end else begin
        m_scan_t++;
      end
      if (clear) begin
        m_count = 0; m_presc = 0; m_wrap = 1'b0;
      end else if (en && m_presc == TD - 1) begin
        m_presc = 0;
        if (up_dn) begin
          m_wrap  = (m_count == MODV - 1);
          m_count = (m_count + 1) % MODV;
        end else begin
          m_wrap  = (m_count == 0);
          m_count = (m_count + MODV - 1) % MODV;
        end
      end else begin
        if (en) m_presc++;
        m_wrap = 1'b0;
      end
      post_rst++;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("count", 32'(count_bcd), 32'(bcd_of(m_count)));
    check("wrap",  32'(wrap),      32'(m_wrap));
    check("sel",   32'(sel),       32'(m_sel));
    check("seg",   32'(seg),       32'(m_seg));
    if (post_rst >= 1) check("onehot", 32'($onehot(sel)), 32'd1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int target, input int budget);
    for (int i = 0; i < budget && m_count != target; i++) step();
    check("until", 32'(count_bcd), 32'(bcd_of(target)));
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; clear = 1'b0;
    steps(2);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_cnt", 32'(count_bcd), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_seg", 32'(seg), 32'h0);

    // Count up from reset: one step per TD cycles.
    en = 1'b1; up_dn = 1'b1;
    steps(40);
    check("s1_cnt", 32'(count_bcd), 32'h10);

    // Roll over 99 -> 00.
    run_until(MODV - 1, 500);
    steps(TD);
    check("s2_cnt",  32'(count_bcd), 32'h00);
    check("s2_wrap", 32'(wrap), 32'd1);
    step();
    check("s2_wrap_off", 32'(wrap), 32'd0);

    // Count down through 00 -> 99 -> 98.
    up_dn = 1'b0;
    run_until(MODV - 1, 2 * TD);
    check("s3_wrap", 32'(wrap), 32'd1);
    run_until(MODV - 2, 2 * TD);
    check("s3_cnt", 32'(count_bcd), 32'h98);

    // Freeze at 37 while the display keeps scanning.
    do_reset();
    en = 1'b1; up_dn = 1'b1;
    run_until(37, 300);
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("s4_cnt", 32'(count_bcd), 32'h37);
      check("s4_seg", 32'(seg), (m_sel == 2'b01) ? 32'h07 : 32'h4F);
    end

    // Clear coincides with a tick at 99.
    en = 1'b1;
    do_reset();
    en = 1'b1;
    run_until(MODV - 1, 500);
    steps(TD - 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("s5_cnt",  32'(count_bcd), 32'h00);
    check("s5_wrap", 32'(wrap), 32'd0);
    steps(TD - 1);
    check("s5_hold", 32'(count_bcd), 32'h00);
    step();
    check("s5_next", 32'(count_bcd), 32'h01);

    // Leading zero display at 05.
    do_reset();
    en = 1'b1;
    run_until(5, 100);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("s6_seg", 32'(seg), (m_sel == 2'b01) ? 32'h6D : 32'(LZ_SEG));
    end

    // Random traffic including mid-run clears and resets.
    for (int i = 0; i < 1500; i++) begin
      en    = ($urandom_range(0, 9) < 8);
      up_dn = $urandom_range(0, 1) == 1;
      clear = ($urandom_range(0, 99) < 2);
      rst   = ($urandom_range(0, 199) < 1);
      step();
    end
    rst = 1'b0; clear = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
